// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use scoreboard.
// Tag entries carry the destination zero-extended to FWD_AW_MAX bits, so one
// struct type serves every REG_AW up to that width. Comparisons against a
// zero-extended source therefore still only distinguish the low REG_AW bits.
package fwd_pkg;

    localparam int FWD_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic                  is_load;
        logic [FWD_AW_MAX-1:0] dest;
    } fwd_entry_t;

    // Select value meaning "take the operand from the register file".
    localparam int SEL_RF = 0;

    // Empty pipeline slot: never matches, never hazards.
    localparam fwd_entry_t FWD_BUBBLE = '{valid: 1'b0, wr: 1'b0, is_load: 1'b0, dest: '0};

endpackage

// File: rtl/fwd_match.sv
// One source operand checked against every tracked stage. Produces the
// youngest-wins bypass select and a load-use hazard flag. Purely combinational.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int REG_AW     = 5,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = 2
) (
    input  logic [REG_AW-1:0]      src,
    input  fwd_entry_t [DEPTH-1:0] entries,
    input  logic                   issue_valid,
    output logic [SEL_W-1:0]       sel,
    output logic                   hazard
);

    localparam logic [SEL_W-1:0] READY_SEL = SEL_W'(LOAD_READY);

    logic [FWD_AW_MAX-1:0] src_ext;
    logic [DEPTH-1:0]      match;
    logic [SEL_W-1:0]      win_sel;
    logic                  win_load;

    assign src_ext = FWD_AW_MAX'(src);

    // Per-stage match; register 0 is hard-wired and never forwards.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = entries[gi].valid & entries[gi].wr
                             & (entries[gi].dest == src_ext)
                             & (entries[gi].dest != '0);
        end
    endgenerate

    // Priority pick: scan oldest to youngest so the youngest match is left standing.
    always_comb begin
        win_sel  = SEL_W'(SEL_RF);
        win_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match[k-1]) begin
                win_sel  = SEL_W'(k);
                win_load = entries[k-1].is_load;
            end
        end
    end

    // win_load is only set by a real match, so win_sel is non-zero here.
    assign hazard = issue_valid & win_load & (win_sel < READY_SEL);
    assign sel    = hazard ? SEL_W'(SEL_RF) : win_sel;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit. Keeps a shadow pipeline of destination
// tags for instructions past DECODE, drives per-operand bypass selects and a
// load-use stall, and counts stall cycles (saturating).
// REG_AW must not exceed fwd_pkg::FWD_AW_MAX.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int  NUM_SRC    = 2,
    parameter int  DEPTH      = 2,
    parameter int  REG_AW     = 5,
    parameter int  LOAD_READY = 2,
    parameter int  CNT_W      = 16,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      advance,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic                      issue_is_load,
    input  logic [REG_AW-1:0]         issue_dest,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_count
);

    // Index j holds entry j+1 (index 0 = ALU-output stage).
    fwd_entry_t [DEPTH-1:0] tags_reg;
    fwd_entry_t             entry1_next;
    logic [NUM_SRC-1:0]     hazard;
    logic [CNT_W-1:0]       count_reg;

    // One matcher per source operand.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_match #(
                .DEPTH      (DEPTH),
                .REG_AW     (REG_AW),
                .LOAD_READY (LOAD_READY),
                .SEL_W      (SEL_W)
            ) u_match (
                .src         (src_addr[gi*REG_AW +: REG_AW]),
                .entries     (tags_reg),
                .issue_valid (issue_valid),
                .sel         (fwd_sel[gi*SEL_W +: SEL_W]),
                .hazard      (hazard[gi])
            );
        end
    endgenerate

    assign stall = |hazard;

    // What enters the ALU-output stage: a bubble unless a live, unstalled instruction issues.
    always_comb begin
        entry1_next = FWD_BUBBLE;
        if (issue_valid && !flush && !stall) begin
            entry1_next = '{valid: 1'b1, wr: issue_wr, is_load: issue_is_load,
                            dest: FWD_AW_MAX'(issue_dest)};
        end
    end

    // Tag shift register; holds whenever the pipeline is not advancing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags_reg <= {DEPTH{FWD_BUBBLE}};
        end else if (advance) begin
            tags_reg[0] <= entry1_next;
            for (int k = 1; k < DEPTH; k++) begin
                tags_reg[k] <= tags_reg[k-1];
            end
        end
    end

    // Saturating count of cycles in which the pipeline really stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (stall && advance && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign stall_count = count_reg;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a table of per-cycle vectors for the
// default configuration, hand sequences for flush/hold/saturation/reset, and a
// second configuration (3 sources, 4 stages, load ready at 3).
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance, flush, issue_valid, issue_wr, issue_is_load;
    logic [4:0]  issue_dest;
    logic [9:0]  src_addr;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_count;

    logic [3:0]  sat_sel;
    logic        sat_stall;
    logic [1:0]  sat_count;

    logic        p_advance, p_flush, p_valid, p_wr, p_load;
    logic [4:0]  p_dest;
    logic [14:0] p_src;
    logic [8:0]  p_sel;
    logic        p_stall;
    logic [15:0] p_count;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    fwd_scoreboard u_dut (
        .clk(clk), .reset(reset), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_is_load(issue_is_load),
        .issue_dest(issue_dest), .src_addr(src_addr),
        .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
    );

    fwd_scoreboard #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_is_load(issue_is_load),
        .issue_dest(issue_dest), .src_addr(src_addr),
        .fwd_sel(sat_sel), .stall(sat_stall), .stall_count(sat_count)
    );

    fwd_scoreboard #(.NUM_SRC(3), .DEPTH(4), .LOAD_READY(3)) u_p3 (
        .clk(clk), .reset(reset), .advance(p_advance), .flush(p_flush),
        .issue_valid(p_valid), .issue_wr(p_wr), .issue_is_load(p_load),
        .issue_dest(p_dest), .src_addr(p_src),
        .fwd_sel(p_sel), .stall(p_stall), .stall_count(p_count)
    );

    typedef struct {
        logic       adv, fl, v, wr, ld;
        logic [4:0] dest, s0, s1;
        int         e0, e1, es;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic adv, fl, v, wr, ld,
                                input logic [4:0] dest, s0, s1,
                                input int e0, e1, es);
        vec_t r;
        r.adv = adv; r.fl = fl; r.v = v; r.wr = wr; r.ld = ld;
        r.dest = dest; r.s0 = s0; r.s1 = s1;
        r.e0 = e0; r.e1 = e1; r.es = es;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle on the default-config pair; entered and left at posedge+1.
    task automatic step(input string name, input logic adv, fl, v, wr, ld,
                        input logic [4:0] dest, s0, s1,
                        input int e0, e1, es);
        advance = adv; flush = fl; issue_valid = v; issue_wr = wr;
        issue_is_load = ld; issue_dest = dest; src_addr = {s1, s0};
        @(negedge clk);
        chk({name, ".sel0"},  int'(fwd_sel[1:0]), e0);
        chk({name, ".sel1"},  int'(fwd_sel[3:2]), e1);
        chk({name, ".stall"}, int'(stall), es);
        $display("%s: sel0=%0d sel1=%0d stall=%0d", name, fwd_sel[1:0], fwd_sel[3:2], stall);
        if (es != 0 && adv) exp_cnt++;
        @(posedge clk); #1;
        chk({name, ".count"},    int'(stall_count), exp_cnt);
        chk({name, ".satcount"}, int'(sat_count), (exp_cnt > 3) ? 3 : exp_cnt);
    endtask

    task automatic idle(input string name);
        step(name, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    // One cycle on the 3-source / 4-stage instance.
    task automatic pstep(input string name, input logic v, wr, ld,
                         input logic [4:0] dest, s0, s1, s2,
                         input int e0, e1, e2, es);
        p_valid = v; p_wr = wr; p_load = ld; p_dest = dest; p_src = {s2, s1, s0};
        @(negedge clk);
        chk({name, ".sel0"},  int'(p_sel[2:0]), e0);
        chk({name, ".sel1"},  int'(p_sel[5:3]), e1);
        chk({name, ".sel2"},  int'(p_sel[8:6]), e2);
        chk({name, ".stall"}, int'(p_stall), es);
        $display("%s: sel=%0d/%0d/%0d stall=%0d", name, p_sel[2:0], p_sel[5:3], p_sel[8:6], p_stall);
        @(posedge clk); #1;
    endtask

    task automatic pidle4();
        for (int i = 0; i < 4; i++)
            pstep("p3_idle", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        //           adv fl  v   wr  ld  dest   s0     s1     e0 e1 es
        tbl[0]  = mk(1,  0,  1,  1,  0,  5'd5,  5'd0,  5'd0,  0, 0, 0);
        tbl[1]  = mk(1,  0,  1,  1,  0,  5'd3,  5'd5,  5'd5,  1, 1, 0);
        tbl[2]  = mk(1,  0,  1,  1,  0,  5'd7,  5'd5,  5'd3,  2, 1, 0);
        tbl[3]  = mk(1,  0,  1,  1,  0,  5'd7,  5'd7,  5'd3,  1, 2, 0);
        tbl[4]  = mk(1,  0,  1,  1,  0,  5'd0,  5'd7,  5'd0,  1, 0, 0);
        tbl[5]  = mk(1,  0,  0,  0,  0,  5'd0,  5'd0,  5'd7,  0, 2, 0);
        tbl[6]  = mk(1,  0,  0,  0,  0,  5'd0,  5'd0,  5'd0,  0, 0, 0);
        tbl[7]  = mk(1,  0,  1,  1,  1,  5'd9,  5'd0,  5'd0,  0, 0, 0);
        tbl[8]  = mk(1,  0,  1,  1,  0,  5'd10, 5'd1,  5'd9,  0, 0, 1);
        tbl[9]  = mk(1,  0,  1,  1,  0,  5'd10, 5'd1,  5'd9,  0, 2, 0);
        tbl[10] = mk(1,  0,  0,  0,  0,  5'd0,  5'd10, 5'd9,  1, 0, 0);

        // Reset state with dependent-looking inputs present.
        reset = 1'b1;
        advance = 1'b1; flush = 1'b0; issue_valid = 1'b1; issue_wr = 1'b1;
        issue_is_load = 1'b1; issue_dest = 5'd9; src_addr = {5'd9, 5'd9};
        p_advance = 1'b1; p_flush = 1'b0; p_valid = 1'b0; p_wr = 1'b0;
        p_load = 1'b0; p_dest = 5'd0; p_src = '0;
        #3;
        chk("reset.sel",   int'(fwd_sel), 0);
        chk("reset.stall", int'(stall), 0);
        chk("reset.count", int'(stall_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec%0d", i), tbl[i].adv, tbl[i].fl, tbl[i].v, tbl[i].wr, tbl[i].ld,
                 tbl[i].dest, tbl[i].s0, tbl[i].s1, tbl[i].e0, tbl[i].e1, tbl[i].es);
        end

        // Flush during a load-use stall, then a plain flush.
        idle("a_idle"); idle("a_idle");
        step("a_load",     1, 0, 1, 1, 1, 5'd9,  5'd0,  5'd9, 0, 0, 0);
        step("a_flstall",  1, 1, 1, 1, 0, 5'd10, 5'd0,  5'd9, 0, 0, 1);
        step("a_after",    1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd9, 0, 2, 0);
        step("a_flush",    1, 1, 1, 1, 0, 5'd12, 5'd0,  5'd0, 0, 0, 0);
        step("a_squashed", 1, 0, 0, 0, 0, 5'd0,  5'd12, 5'd0, 0, 0, 0);

        // Hold for three cycles in the middle of a stall.
        idle("b_idle"); idle("b_idle");
        step("b_load", 1, 0, 1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("b_hold", 0, 0, 1, 1, 0, 5'd10, 5'd0, 5'd9, 0, 0, 1);
        step("b_stall", 1, 0, 1, 1, 0, 5'd10, 5'd0, 5'd9, 0, 0, 1);
        step("b_fwd",   1, 0, 1, 1, 0, 5'd10, 5'd0, 5'd9, 0, 2, 0);

        // Two more stalls: 5 in total, the 2-bit counter must sit at 3.
        for (int i = 0; i < 2; i++) begin
            step("s_load",  1, 0, 1, 1, 1, 5'd9,  5'd0, 5'd0, 0, 0, 0);
            step("s_stall", 1, 0, 1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 1);
            step("s_fwd",   1, 0, 0, 0, 0, 5'd0,  5'd0, 5'd9, 0, 2, 0);
        end

        // Deeper configuration: load dest=4 followed at distances 1, 2, 3.
        idle("p_main_idle");
        pidle4();
        pstep("p3_d1_load", 1, 1, 1, 5'd4, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        pstep("p3_d1_use",  1, 1, 0, 5'd2, 5'd4, 5'd1, 5'd4, 0, 0, 0, 1);
        pidle4();
        pstep("p3_d2_load", 1, 1, 1, 5'd4, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        pstep("p3_d2_fill", 1, 1, 0, 5'd1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        pstep("p3_d2_use",  1, 1, 0, 5'd2, 5'd4, 5'd1, 5'd4, 0, 1, 0, 1);
        pidle4();
        pstep("p3_d3_load", 1, 1, 1, 5'd4, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        pstep("p3_d3_fill", 1, 1, 0, 5'd1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        pstep("p3_d3_fill", 1, 1, 0, 5'd1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        pstep("p3_d3_use",  1, 1, 0, 5'd2, 5'd4, 5'd1, 5'd4, 3, 1, 3, 0);

        // Asynchronous reset in the middle of a stall cycle.
        step("c_load", 1, 0, 1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0, 0);
        issue_is_load = 1'b0; issue_dest = 5'd10; src_addr = {5'd9, 5'd0};
        @(negedge clk);
        chk("c_prestall", int'(stall), 1);
        #1 reset = 1'b1;
        #1;
        chk("c_rst.stall",    int'(stall), 0);
        chk("c_rst.sel",      int'(fwd_sel), 0);
        chk("c_rst.count",    int'(stall_count), 0);
        chk("c_rst.satcount", int'(sat_count), 0);
        $display("c_reset: sel=%0d stall=%0d count=%0d", fwd_sel, stall, stall_count);
        exp_cnt = 0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        step("c_post", 1, 0, 1, 1, 0, 5'd10, 5'd0, 5'd9, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
